// File: rtl/seq_minmax_serial_accum.sv
// Serial min/max reducer: accumulates NGROUP unsigned samples from a val/rdy stream
// and presents their min/max on a val/rdy output held in registers separate from the accumulators.
module seq_minmax_serial_accum #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned NGROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] min,
  output logic [NBITS-1:0] max
);

  localparam int unsigned CntW = (NGROUP > 2) ? $clog2(NGROUP) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NGROUP - 1);

  typedef enum logic {StAccum, StHold} state_e;

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic [NBITS-1:0]  acc_min_q, acc_max_q;
  logic [NBITS-1:0]  min_q, max_q;
  logic              out_val_q;

  logic              in_xfer, out_xfer, last;
  logic [NBITS-1:0]  min_d, max_d;

  always_comb begin
    in_rdy = 1'b0;
    if (!reset) begin
      in_rdy = (state_q == StAccum) ? 1'b1 : out_rdy;
    end
    in_xfer  = in_val & in_rdy;
    out_xfer = out_val_q & out_rdy;
    last     = (count_q == CntLast);
    // First sample of a group seeds the accumulators without comparing.
    if (count_q == '0) begin
      min_d = in_msg;
      max_d = in_msg;
    end else begin
      min_d = (in_msg < acc_min_q) ? in_msg : acc_min_q;
      max_d = (in_msg > acc_max_q) ? in_msg : acc_max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAccum;
      count_q   <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
      out_val_q <= 1'b0;
    end else begin
      if (out_xfer) begin
        out_val_q <= 1'b0;
        state_q   <= StAccum;
      end
      if (in_xfer) begin
        acc_min_q <= min_d;
        acc_max_q <= max_d;
        if (last) begin
          min_q     <= min_d;
          max_q     <= max_d;
          out_val_q <= 1'b1;
          state_q   <= StHold;
          count_q   <= '0;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign out_val = out_val_q;
  assign min     = min_q;
  assign max     = max_q;

endmodule

// File: tb/tb_seq_minmax_serial_accum.sv
// Directed and randomised checks of seq_minmax_serial_accum against hand-computed
// results and a small reference model of the group reduction.
module tb_seq_minmax_serial_accum;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_msg;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] dut_min;
  logic [7:0] dut_max;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_minmax_serial_accum #(
    .NBITS  (8),
    .NGROUP (4)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .min     (dut_min),
    .max     (dut_max)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one sample and hold it until it is accepted (bounded wait).
  task automatic push(input logic [7:0] v);
    int waited;
    in_val = 1'b1;
    in_msg = v;
    waited = 0;
    @(negedge clk);
    while (!in_rdy && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_rdy) check("push_timeout", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic push_group(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] emin,
                            input logic [7:0] emax, input string tag);
    push(a);
    push(b);
    push(c);
    push(d);
    check({tag, "_val"}, 32'(out_val), 32'd1);
    check({tag, "_min"}, 32'(dut_min), 32'(emin));
    check({tag, "_max"}, 32'(dut_max), 32'(emax));
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] e;
  int          sent, got, cycles, cnt;
  logic [7:0]  amin, amax;
  logic        acc;

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_min", 32'(dut_min), 32'd0);
    check("rst_max", 32'(dut_max), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ordering, duplicates and unsigned extremes
    out_rdy = 1'b1;
    push_group(8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h04, "asc");
    push_group(8'h04, 8'h03, 8'h02, 8'h01, 8'h01, 8'h04, "desc");
    push_group(8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, "dup");
    push_group(8'h02, 8'h01, 8'h02, 8'h01, 8'h01, 8'h02, "tie");
    push_group(8'hFF, 8'hFE, 8'hFC, 8'hFD, 8'hFC, 8'hFF, "big");
    @(posedge clk);
    #1;
    check("retire_val", 32'(out_val), 32'd0);
    check("retire_min", 32'(dut_min), 32'hFC);

    // Backpressure: result held, input stalled
    out_rdy = 1'b0;
    push_group(8'd10, 8'd20, 8'd30, 8'd40, 8'd10, 8'd40, "bp");
    in_val = 1'b1;
    in_msg = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_rdy", 32'(in_rdy), 32'd0);
      check("bp_out_val", 32'(out_val), 32'd1);
      check("bp_min", 32'(dut_min), 32'd10);
      check("bp_max", 32'(dut_max), 32'd40);
      @(posedge clk);
      #1;
    end
    out_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;
    in_val = 1'b0;
    check("bp_retired", 32'(out_val), 32'd0);
    push(8'h06);
    push(8'h07);
    push(8'h08);
    check("bp2_val", 32'(out_val), 32'd1);
    check("bp2_min", 32'(dut_min), 32'h05);
    check("bp2_max", 32'(dut_max), 32'h08);

    // Reset mid-group discards partial state
    push(8'd200);
    push(8'd201);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_rdy", 32'(in_rdy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_val", 32'(out_val), 32'd0);
    check("rst_mid_min", 32'(dut_min), 32'd0);
    push(8'd1);
    check("rst_g1_val", 32'(out_val), 32'd0);
    push(8'd2);
    check("rst_g2_val", 32'(out_val), 32'd0);
    push(8'd3);
    check("rst_g3_val", 32'(out_val), 32'd0);
    push(8'd4);
    check("rst_grp_val", 32'(out_val), 32'd1);
    check("rst_grp_min", 32'(dut_min), 32'd1);
    check("rst_grp_max", 32'(dut_max), 32'd4);

    // Random gaps and stalls against a reference model; pending {1,4} retires first
    exp_q.push_back({8'd1, 8'd4});
    sent   = 0;
    got    = 0;
    cycles = 0;
    cnt    = 0;
    amin   = '0;
    amax   = '0;
    while (got < 21 && cycles < 3000) begin
      cycles++;
      @(negedge clk);
      out_rdy = ($urandom_range(0, 3) != 0);
      if (!in_val && sent < 80 && $urandom_range(0, 2) != 0) begin
        in_val = 1'b1;
        in_msg = 8'($urandom);
      end
      #1;
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", 32'(out_val), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_min", 32'(dut_min), 32'(e[15:8]));
          check("rnd_max", 32'(dut_max), 32'(e[7:0]));
          got++;
        end
      end
      acc = in_val && in_rdy;
      if (acc) begin
        if (cnt == 0) begin
          amin = in_msg;
          amax = in_msg;
        end else begin
          if (in_msg < amin) amin = in_msg;
          if (in_msg > amax) amax = in_msg;
        end
        if (cnt == 3) begin
          exp_q.push_back({amin, amax});
          cnt = 0;
        end else begin
          cnt++;
        end
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) in_val = 1'b0;
    end
    check("rnd_groups", 32'(got), 32'd21);
    check("rnd_leftover", 32'(exp_q.size()), 32'd0);
    check("rnd_sent", 32'(sent), 32'd80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
